// File: rtl/pe_sad.sv
// rtl/pe_sad.sv - SAD processing element for the motion-estimation systolic array
module pe_sad #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S1,
    input  logic [WIDTH-1:0] S2,
    input  logic             S1S2mux,
    input  logic             newdist,
    output logic [WIDTH-1:0] accumulate,
    output logic [WIDTH-1:0] rpipe,
    output logic             carry
);

    logic [WIDTH-1:0] s_sel;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   sum;

    always_comb begin
        s_sel = S1S2mux ? S1 : S2;
        diff  = (R >= s_sel) ? (R - s_sel) : (s_sel - R);
        sum   = {1'b0, accumulate} + {1'b0, diff};
    end

    // Once saturated, the accumulator re-saturates on every add, so it holds all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            accumulate <= '0;
            rpipe      <= '0;
            carry      <= 1'b0;
        end else begin
            rpipe <= R;
            if (newdist) begin
                accumulate <= diff;
                carry      <= 1'b0;
            end else if (sum[WIDTH]) begin
                accumulate <= '1;
                carry      <= 1'b1;
            end else begin
                accumulate <= sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pe_sad.sv
// tb/tb_pe_sad.sv - directed scoreboard bench for pe_sad
module tb_pe_sad;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] R, S1, S2;
    logic       S1S2mux, newdist;
    logic [7:0] accumulate, rpipe;
    logic       carry;

    int checks   = 0;
    int failures = 0;

    logic [16:0] sb_q[$];

    pe_sad #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .R          (R),
        .S1         (S1),
        .S2         (S2),
        .S1S2mux    (S1S2mux),
        .newdist    (newdist),
        .accumulate (accumulate),
        .rpipe      (rpipe),
        .carry      (carry)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic rst, input logic nd, input logic mux,
                        input logic [7:0] r, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] e_acc, input logic [7:0] e_rp, input logic e_c);
        logic [16:0] exp_v;
        reset   = rst;
        newdist = nd;
        S1S2mux = mux;
        R       = r;
        S1      = s1;
        S2      = s2;
        sb_q.push_back({e_acc, e_rp, e_c});
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        assert (accumulate === exp_v[16:9]) else begin
            failures++;
            $error("FAIL %s accumulate: got %02h expected %02h", tag, accumulate, exp_v[16:9]);
        end
        checks++;
        assert (rpipe === exp_v[8:1]) else begin
            failures++;
            $error("FAIL %s rpipe: got %02h expected %02h", tag, rpipe, exp_v[8:1]);
        end
        checks++;
        assert (carry === exp_v[0]) else begin
            failures++;
            $error("FAIL %s carry: got %0b expected %0b", tag, carry, exp_v[0]);
        end
    endtask

    initial begin
        reset = 1'b1; newdist = 1'b0; S1S2mux = 1'b0;
        R = '0; S1 = '0; S2 = '0;

        step("reset0", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        step("reset1", 1, 0, 0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 0);

        step("load8",  0, 1, 1, 8'h08, 8'h00, 8'h00, 8'h08, 8'h08, 0);
        step("acc09",  0, 0, 1, 8'h00, 8'h01, 8'h00, 8'h09, 8'h00, 0);
        step("acc0d",  0, 0, 0, 8'h01, 8'h00, 8'h05, 8'h0D, 8'h01, 0);
        step("acc0e",  0, 0, 1, 8'h02, 8'h01, 8'h00, 8'h0E, 8'h02, 0);
        step("acc0f",  0, 0, 0, 8'h02, 8'h00, 8'h01, 8'h0F, 8'h02, 0);

        step("sat",    0, 0, 1, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h05, 1);
        step("hold1",  0, 0, 0, 8'h02, 8'h00, 8'h01, 8'hFF, 8'h02, 1);
        step("hold2",  0, 0, 0, 8'h02, 8'h00, 8'h01, 8'hFF, 8'h02, 1);
        step("hold0d", 0, 0, 0, 8'h04, 8'h00, 8'h04, 8'hFF, 8'h04, 1);

        step("newsat", 0, 1, 0, 8'h03, 8'h00, 8'h07, 8'h04, 8'h03, 0);

        step("rpA5",   0, 0, 1, 8'hA5, 8'h00, 8'h00, 8'hA9, 8'hA5, 0);
        step("rp3C",   0, 1, 0, 8'h3C, 8'h00, 8'h3C, 8'h00, 8'h3C, 0);

        step("pre0e",  0, 1, 1, 8'h0E, 8'h00, 8'h00, 8'h0E, 8'h0E, 0);
        step("rstmid", 1, 1, 1, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        step("resume", 0, 0, 1, 8'h03, 8'h00, 8'h00, 8'h03, 8'h03, 0);

        step("edgeFF", 0, 0, 1, 8'h00, 8'hFC, 8'h00, 8'hFF, 8'h00, 0);
        step("ovf1",   0, 0, 0, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h01, 1);
        step("rstsat", 1, 0, 0, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        step("after",  0, 0, 0, 8'h10, 8'h00, 8'h30, 8'h20, 8'h10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
